text_pixel_gen: RTL

Text-mode pixel generator for the GPU core: the requesting side of the character-glyph ROM and text-RAM read ports. For each pixel position from the display timing generator it fetches the character/attribute word from text RAM and issues `{char, glyph_row}` to the charset ROM. It then selects the glyph bit and emits a 4-bit colour index with hsync/vsync delayed to match. It sits between the timing generator and the palette/DAC stage and adds a blinking underline cursor.

---
 rtl/text_pixel_gen_pkg.sv | 39 +++
 rtl/text_pixel_gen_sideband_delay.sv | 27 ++
 rtl/text_pixel_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/text_pixel_gen_pkg.sv
// Shared text-mode constants: font geometry, attribute word layout and the
// sideband payloads carried alongside the pixel pipeline.
package text_pixel_gen_pkg;

   localparam int unsigned FONT_W           = 8;
   localparam int unsigned FONT_H           = 16;
   localparam int unsigned COL_W            = $clog2(FONT_W);
   localparam int unsigned ROW_W            = $clog2(FONT_H);
   localparam int unsigned ADDR_W           = 12;
   localparam int unsigned CHAR_LSB         = 0;
   localparam int unsigned CHAR_W           = 8;
   localparam int unsigned FG_LSB           = 8;
   localparam int unsigned BG_LSB           = 12;
   localparam int unsigned COLOR_W          = 4;
   localparam int unsigned CURSOR_ROW_FIRST = 14;

   typedef struct packed {
      logic             active;
      logic             hsync;
      logic             vsync;
      logic [COL_W-1:0] col;
      logic [ROW_W-1:0] row;
      logic             cursor_hit;
   } sideband_t;

   typedef struct packed {
      sideband_t          sb;
      logic [COLOR_W-1:0] fg;
      logic [COLOR_W-1:0] bg;
   } attr_sideband_t;

   localparam sideband_t SB_IDLE = '{
      active: 1'b0, hsync: 1'b1, vsync: 1'b1,
      col: '0, row: '0, cursor_hit: 1'b0
   };

   localparam attr_sideband_t ASB_IDLE = '{sb: SB_IDLE, fg: '0, bg: '0};

endpackage

// File: rtl/text_pixel_gen_sideband_delay.sv
// N-stage, W-bit register delay line with a per-bit reset value, used to keep
// pixel sidebands aligned with the memory fetch pipeline.
module sideband_delay #(
   parameter int unsigned   N       = 1,
   parameter int unsigned   W       = 1,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++) stage[i] <= RST_VAL;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < int'(N); i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[N-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: text RAM fetch, glyph ROM fetch, bit select with
// blinking underline cursor, and sync delay matched to the 3-cycle pipeline.
module text_pixel_gen
   import text_pixel_gen_pkg::*;
#(
   parameter int unsigned COLS       = 80,
   parameter int unsigned ROWS       = 30,
   parameter int unsigned BLINK_BITS = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic              active,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              cursor_en,
   input  logic [6:0]        cursor_col,
   input  logic [4:0]        cursor_row,
   output logic [ADDR_W-1:0] tram_addr,
   input  logic [15:0]       tram_q,
   output logic [ADDR_W-1:0] glyph_addr,
   input  logic [7:0]        glyph_q,
   output logic [3:0]        pix_color,
   output logic              hsync_out,
   output logic              vsync_out
);

   localparam int unsigned CELLS = COLS * ROWS;

   logic [6:0]            cx;
   logic [5:0]            cy;
   logic [ADDR_W-1:0]     cell_addr_c;
   logic                  cursor_hit_c;
   sideband_t             sb0_c;
   sideband_t             sb1;
   attr_sideband_t        asb1_c;
   attr_sideband_t        asb2;
   logic                  pixel_bit_c;
   logic                  blink_on;
   logic                  vsync_q;
   logic [BLINK_BITS-1:0] frame_cnt;

   assign cx = pix_x[9:COL_W];
   assign cy = pix_y[9:ROW_W];

   // Row-major cell address; the 80-column layout uses 64+16 shift-add.
   if (COLS == 80 && CELLS <= (1 << ADDR_W)) begin : g_shift_add
      assign cell_addr_c = ADDR_W'({cy, 6'b0}) + ADDR_W'({cy, 4'b0}) + ADDR_W'(cx);
   end else begin : g_mul
      assign cell_addr_c = ADDR_W'(32'(cy) * COLS + 32'(cx));
   end

   assign cursor_hit_c = cursor_en && (cx == cursor_col) && (cy == {1'b0, cursor_row});

   assign sb0_c = '{
      active: active, hsync: hsync_in, vsync: vsync_in,
      col: pix_x[COL_W-1:0], row: pix_y[ROW_W-1:0], cursor_hit: cursor_hit_c
   };

   sideband_delay #(.N(1), .W($bits(sideband_t)), .RST_VAL(SB_IDLE)) u_sb1 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sb0_c),
      .q     (sb1)
   );

   assign asb1_c = '{
      sb: sb1,
      fg: tram_q[FG_LSB +: COLOR_W],
      bg: tram_q[BG_LSB +: COLOR_W]
   };

   sideband_delay #(.N(1), .W($bits(attr_sideband_t)), .RST_VAL(ASB_IDLE)) u_sb2 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (asb1_c),
      .q     (asb2)
   );

   // Stage 0/1 memory address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tram_addr  <= '0;
         glyph_addr <= '0;
      end else begin
         tram_addr  <= cell_addr_c;
         glyph_addr <= {tram_q[CHAR_LSB +: CHAR_W], sb1.row};
      end
   end

   // Frame counter advances on each vsync falling edge; MSB is the blink phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q   <= 1'b1;
         frame_cnt <= '0;
      end else begin
         vsync_q <= vsync_in;
         if (vsync_q && !vsync_in) frame_cnt <= frame_cnt + BLINK_BITS'(1);
      end
   end

   assign blink_on = ~frame_cnt[BLINK_BITS-1];

   always_comb begin
      pixel_bit_c = glyph_q[COL_W'(COL_W'(FONT_W - 1) - asb2.sb.col)];
      if (asb2.sb.cursor_hit && blink_on && (asb2.sb.row >= ROW_W'(CURSOR_ROW_FIRST)))
         pixel_bit_c = 1'b1;
   end

   // Stage 2 colour and sync outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_color <= '0;
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
      end else begin
         pix_color <= asb2.sb.active ? (pixel_bit_c ? asb2.fg : asb2.bg) : '0;
         hsync_out <= asb2.sb.hsync;
         vsync_out <= asb2.sb.vsync;
      end
   end

endmodule
